sh7604_dbus_arbiter: RTL
========================

Name: sh7604_dbus_arbiter

Overview:
- Two-master arbiter for the SH7604 external data bus (DBUS), sitting between the CPU core load/store/fetch port, the DMAC bus-master port, and the BSC.
- Grants one owner at a time, honours LOCK and 4-beat BURST sequences, and steers WAIT to the masters.
- Generates the BSC_ACK strobe the DMAC uses to drive DACKn.
- Enforces anti-starvation so a continuous DMAC stream cannot lock the CPU out indefinitely.

Parameters:
- STARVE_MAX, 8, maximum consecutive DMAC-granted transfers while the CPU is pending before a forced CPU slot.
- DMA_PRIO, 1, 1 = DMAC wins simultaneous new requests; 0 = CPU wins.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE_R  in  1  rising-phase clock enable
- CE_F  in  1  falling-phase clock enable (all arbitration decisions)
- C_A, C_DO  in  32 each  CPU address / write data
- C_BA  in  4  CPU byte enables
- C_WE, C_REQ, C_LOCK, C_BURST  in  1 each  CPU control
- C_WAIT  out  1  CPU stall
- D_A, D_DO  in  32 each  DMAC address / write data
- D_BA  in  4  DMAC byte enables
- D_WE, D_REQ, D_LOCK, D_BURST  in  1 each  DMAC control
- D_WAIT  out  1  DMAC stall
- M_A, M_DO  out  32 each  muxed address / write data to BSC
- M_BA  out  4  muxed byte enables
- M_WE, M_REQ, M_LOCK, M_BURST  out  1 each  muxed control
- M_WAIT  in  1  BSC wait
- BSC_ACK  out  1  DMAC transfer-accept strobe
- OWNER  out  2  current owner: 00 none, 01 CPU, 10 DMAC

Behaviour:
- Reset (RST_N low): state IDLE, OWNER=00, beat counter 0, starve counter 0. All M_* outputs 0; C_WAIT=D_WAIT=1 only while the corresponding REQ is high, else 0; BSC_ACK=0.
- States: IDLE, CPU, DMA. State updates only on CE_F.
- IDLE transitions:
  - Only C_REQ high -> CPU.
  - Only D_REQ high -> DMA.
  - Both high -> DMA if DMA_PRIO=1, else CPU.
  - Starve override: if starve counter == STARVE_MAX and C_REQ is high -> CPU.
- Beat complete = CE_F & M_REQ & !M_WAIT.
- Beat counter (2 bits):
  - Loads 3 on the first beat of an owner's access when its BURST=1.
  - Decrements on each completed beat.
  - While nonzero, no handover and BURST stays asserted.
- Release from CPU or DMA, evaluated at CE_F:
  - Owner REQ low -> release.
  - Beat complete with beat counter 0 and owner LOCK low -> release.
  - On release, re-arbitrate in the same CE_F using the IDLE rules. No dead cycle; back-to-back handover is allowed.
- LOCK high: owner holds the bus across accesses, including idle gaps with REQ low. This sustains the DMAC read->write pair and CPU TAS. Exception: the starve override never breaks a LOCK.
- Starve counter:
  - Increments on each completed DMAC beat with counter 0 while C_REQ is high.
  - Clears on any CPU grant or when C_REQ is low.
  - Saturates at STARVE_MAX.
- Muxing is combinational from OWNER. M_* equal the owner's signals; with owner none, M_* = 0.
- WAIT outputs:
  - C_WAIT = C_REQ & (OWNER!=CPU | M_WAIT).
  - D_WAIT = D_REQ & (OWNER!=DMA | M_WAIT).
- BSC_ACK = (OWNER==DMA) & D_REQ & !M_WAIT. It is combinational and aligned with the accepted beat.
- Read data is not muxed: both masters see M_DI directly outside this block.
- Simultaneous owner-release and new request: the new request is granted in the same CE_F.
- REQ dropped mid-burst (illegal): release immediately and clear the beat counter.

Optional Feature:
- Macro: DBUS_ARB_STATS_EN.
- When defined:
  - Adds 16-bit saturating counters CPU_GRANTS, DMA_GRANTS and CONTENTION (both REQ high at an arbitration point).
  - Counters reset on RST_N.
  - Exposed on outputs STAT_CPU, STAT_DMA, STAT_CONT.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Add to SH7604_PKG:
  - typedef DBUS_OWNER_t (enum NONE=2'b00, CPU=2'b01, DMA=2'b10).
  - typedef DBUS_ARB_STATE_t (IDLE, CPU, DMA).
  - constant DBUS_BURST_BEATS=4.
- One sub-module, sh7604_dbus_mux: purely combinational owner-select of A/DO/BA/WE/REQ/LOCK/BURST. The FSM, counters and WAIT/ACK logic stay in the top.

Test Plan:
- Single CPU read C_A=0x06000010, M_WAIT=0 -> granted at the next CE_F, M_A=0x06000010, OWNER=01, C_WAIT falls; after REQ drops, OWNER=00.
- Simultaneous C_REQ and D_REQ, DMA_PRIO=1 -> OWNER=10 first, BSC_ACK pulses on the DMAC beat, then CPU is granted at the release CE_F with no idle cycle.
- DMAC burst (D_BURST=1) with M_WAIT=1 for 2 cycles on beat 2, CPU pending throughout -> all 4 beats stay with the DMAC (M_BURST=1); CPU is granted only after beat 4 completes.
- DMAC D_LOCK=1 across read 0x20000000 then write 0x06010000, with a 1-cycle REQ gap -> OWNER stays 10 through the gap; CPU C_WAIT=1 until LOCK drops.
- STARVE_MAX=8, continuous unlocked DMAC single transfers plus constant C_REQ -> after exactly 8 DMAC beats the CPU gets one beat, then the DMAC resumes.
- RST_N asserted mid-burst (beat 2) -> M_REQ=0, OWNER=00 immediately; after release, the first CE_F re-arbitrates from IDLE with beat counter 0.

Source files
------------

// File: rtl/sh7604_pkg.sv
// Shared SH7604 types: DBUS owner/arbiter-state encodings and the burst length.
package sh7604_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DMA  = 2'b10
    } DBUS_OWNER_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CPU  = 2'b01,
        ST_DMA  = 2'b10
    } DBUS_ARB_STATE_t;

    localparam int DBUS_BURST_BEATS = 4;

    function automatic DBUS_OWNER_t dbus_owner_of(input DBUS_ARB_STATE_t st);
        case (st)
            ST_CPU:  return OWN_CPU;
            ST_DMA:  return OWN_DMA;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sh7604_dbus_mux.sv
// Owner select of the CPU/DMAC request bundles onto the BSC side; all zero with no owner.
module sh7604_dbus_mux
    import sh7604_pkg::*;
(
    input  DBUS_OWNER_t OWNER,
    input  logic [31:0] C_A,
    input  logic [31:0] C_DO,
    input  logic [3:0]  C_BA,
    input  logic        C_WE,
    input  logic        C_REQ,
    input  logic        C_LOCK,
    input  logic        C_BURST,
    input  logic [31:0] D_A,
    input  logic [31:0] D_DO,
    input  logic [3:0]  D_BA,
    input  logic        D_WE,
    input  logic        D_REQ,
    input  logic        D_LOCK,
    input  logic        D_BURST,
    output logic [31:0] M_A,
    output logic [31:0] M_DO,
    output logic [3:0]  M_BA,
    output logic        M_WE,
    output logic        M_REQ,
    output logic        M_LOCK,
    output logic        M_BURST
);

    always_comb begin
        M_A     = '0;
        M_DO    = '0;
        M_BA    = '0;
        M_WE    = 1'b0;
        M_REQ   = 1'b0;
        M_LOCK  = 1'b0;
        M_BURST = 1'b0;
        case (OWNER)
            OWN_CPU: begin
                M_A     = C_A;
                M_DO    = C_DO;
                M_BA    = C_BA;
                M_WE    = C_WE;
                M_REQ   = C_REQ;
                M_LOCK  = C_LOCK;
                M_BURST = C_BURST;
            end
            OWN_DMA: begin
                M_A     = D_A;
                M_DO    = D_DO;
                M_BA    = D_BA;
                M_WE    = D_WE;
                M_REQ   = D_REQ;
                M_LOCK  = D_LOCK;
                M_BURST = D_BURST;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sh7604_dbus_arbiter.sv
// CPU/DMAC arbiter for the SH7604 external data bus: LOCK, 4-beat bursts, anti-starvation.
// Define DBUS_ARB_STATS_EN to add grant/contention counters on STAT_CPU/STAT_DMA/STAT_CONT.
module sh7604_dbus_arbiter
    import sh7604_pkg::*;
#(
    parameter int STARVE_MAX = 8,
    parameter bit DMA_PRIO   = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic [31:0] C_A,
    input  logic [31:0] C_DO,
    input  logic [3:0]  C_BA,
    input  logic        C_WE,
    input  logic        C_REQ,
    input  logic        C_LOCK,
    input  logic        C_BURST,
    output logic        C_WAIT,
    input  logic [31:0] D_A,
    input  logic [31:0] D_DO,
    input  logic [3:0]  D_BA,
    input  logic        D_WE,
    input  logic        D_REQ,
    input  logic        D_LOCK,
    input  logic        D_BURST,
    output logic        D_WAIT,
    output logic [31:0] M_A,
    output logic [31:0] M_DO,
    output logic [3:0]  M_BA,
    output logic        M_WE,
    output logic        M_REQ,
    output logic        M_LOCK,
    output logic        M_BURST,
    input  logic        M_WAIT,
    output logic        BSC_ACK,
    output logic [1:0]  OWNER
`ifdef DBUS_ARB_STATS_EN
    ,
    output logic [15:0] STAT_CPU,
    output logic [15:0] STAT_DMA,
    output logic [15:0] STAT_CONT
`endif
);

    localparam int              SW       = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   SMAX     = SW'(STARVE_MAX);
    localparam logic [1:0]      BEAT_RLD = 2'(DBUS_BURST_BEATS - 1);

    DBUS_ARB_STATE_t state, arb_pick;
    DBUS_OWNER_t     owner;
    logic [1:0]      beat_cnt;
    logic [SW-1:0]   starve_cnt, starve_nxt;
    logic            burst_raw, beat_done, first_burst, last_beat, release_bus, arb_point;

    // Every decision is taken on the falling phase; the rising enable has no role here.
    logic unused_ce_r;
    assign unused_ce_r = CE_R;

    assign owner = dbus_owner_of(state);
    assign OWNER = owner;

    sh7604_dbus_mux u_mux (
        .OWNER   (owner),
        .C_A     (C_A),
        .C_DO    (C_DO),
        .C_BA    (C_BA),
        .C_WE    (C_WE),
        .C_REQ   (C_REQ),
        .C_LOCK  (C_LOCK),
        .C_BURST (C_BURST),
        .D_A     (D_A),
        .D_DO    (D_DO),
        .D_BA    (D_BA),
        .D_WE    (D_WE),
        .D_REQ   (D_REQ),
        .D_LOCK  (D_LOCK),
        .D_BURST (D_BURST),
        .M_A     (M_A),
        .M_DO    (M_DO),
        .M_BA    (M_BA),
        .M_WE    (M_WE),
        .M_REQ   (M_REQ),
        .M_LOCK  (M_LOCK),
        .M_BURST (burst_raw)
    );

    assign M_BURST = burst_raw | (beat_cnt != 2'd0);

    assign beat_done   = CE_F & M_REQ & ~M_WAIT;
    assign first_burst = beat_done & (beat_cnt == 2'd0) & burst_raw;
    assign last_beat   = beat_done & ((beat_cnt == 2'd1) | ((beat_cnt == 2'd0) & ~burst_raw));

    // An unlocked owner leaves on REQ low or its last beat; a REQ drop mid-burst always releases.
    assign release_bus = (state != ST_IDLE) & CE_F &
                         ((~M_REQ & (~M_LOCK | (beat_cnt != 2'd0))) | (last_beat & ~M_LOCK));
    assign arb_point   = CE_F & ((state == ST_IDLE) | release_bus);

    always_comb begin
        starve_nxt = starve_cnt;
        if (!C_REQ)
            starve_nxt = '0;
        else if ((state == ST_DMA) && beat_done && (beat_cnt == 2'd0) && (starve_cnt != SMAX))
            starve_nxt = starve_cnt + 1'b1;
    end

    // Uses the post-beat starve count so the CPU slot lands right after the STARVE_MAX-th beat.
    always_comb begin
        arb_pick = ST_IDLE;
        if (C_REQ && (starve_nxt == SMAX))
            arb_pick = ST_CPU;
        else if (C_REQ && D_REQ) begin
            if (DMA_PRIO) arb_pick = ST_DMA;
            else          arb_pick = ST_CPU;
        end
        else if (C_REQ)
            arb_pick = ST_CPU;
        else if (D_REQ)
            arb_pick = ST_DMA;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            beat_cnt   <= 2'd0;
            starve_cnt <= '0;
        end else if (CE_F) begin
            if (arb_point)
                state <= arb_pick;

            if (release_bus)
                beat_cnt <= 2'd0;
            else if (first_burst)
                beat_cnt <= BEAT_RLD;
            else if (beat_done && (beat_cnt != 2'd0))
                beat_cnt <= beat_cnt - 2'd1;

            if (arb_point && (arb_pick == ST_CPU))
                starve_cnt <= '0;
            else
                starve_cnt <= starve_nxt;
        end
    end

    assign C_WAIT  = C_REQ & ((state != ST_CPU) | M_WAIT);
    assign D_WAIT  = D_REQ & ((state != ST_DMA) | M_WAIT);
    assign BSC_ACK = (state == ST_DMA) & D_REQ & ~M_WAIT;

`ifdef DBUS_ARB_STATS_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            STAT_CPU  <= 16'd0;
            STAT_DMA  <= 16'd0;
            STAT_CONT <= 16'd0;
        end else if (arb_point) begin
            if ((arb_pick == ST_CPU) && (STAT_CPU != 16'hFFFF))
                STAT_CPU <= STAT_CPU + 16'd1;
            if ((arb_pick == ST_DMA) && (STAT_DMA != 16'hFFFF))
                STAT_DMA <= STAT_DMA + 16'd1;
            if (C_REQ && D_REQ && (STAT_CONT != 16'hFFFF))
                STAT_CONT <= STAT_CONT + 16'd1;
        end
    end
`endif

endmodule
